quad_encoder_gen: RTL and testbench



---
 rtl/quad_encoder_gen.sv | 162 ++++++++++++++++
 tb/tb_quad_encoder_gen.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/quad_encoder_gen.sv
// Quadrature encoder emulator: turns H-bridge direction commands and PWM duty into A/B phases and position counts.
// Optional per-side revolution index is built when QUAD_ENC_INDEX_EN is defined.
module quad_encoder_side #(
  parameter int unsigned STEP_DIV       = 64,
  parameter int unsigned COUNTS_PER_REV = 1440
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        pwm,
  input  logic        drv_a,
  input  logic        drv_b,
  output logic [1:0]  enc,
  output logic [15:0] pos,
  output logic        step,
  output logic        idx
);
  typedef enum logic [1:0] {DIR_STOP = 2'd0, DIR_FWD = 2'd1, DIR_REV = 2'd2} dir_t;

  localparam logic [15:0] ACC_MAX = 16'(STEP_DIV - 32'd1);

  dir_t        dir_s, last_dir_r, last_dir_nx_s;
  logic [15:0] acc_r, acc_nx_s;
  logic [1:0]  enc_r, enc_nx_s;
  logic [15:0] pos_r, pos_nx_s;
  logic        step_r, step_nx_s;

  // Gray sequence as {B,A}: forward 00->10->11->01, reverse runs it backwards
  function automatic logic [1:0] next_enc(input logic [1:0] cur, input logic fwd);
    case (cur)
      2'b00:   next_enc = fwd ? 2'b10 : 2'b01;
      2'b10:   next_enc = fwd ? 2'b11 : 2'b00;
      2'b11:   next_enc = fwd ? 2'b01 : 2'b10;
      2'b01:   next_enc = fwd ? 2'b00 : 2'b11;
      default: next_enc = 2'b00;
    endcase
  endfunction

  // Bridge input pair to direction; both-low and both-high are brake
  always_comb begin
    case ({drv_a, drv_b})
      2'b10:   dir_s = DIR_FWD;
      2'b01:   dir_s = DIR_REV;
      default: dir_s = DIR_STOP;
    endcase
  end

`ifdef QUAD_ENC_INDEX_EN
  localparam logic [31:0] REV_MAX = 32'(COUNTS_PER_REV - 32'd1);
  logic [31:0] rev_r, rev_nx_s;
  logic        idx_r;
`endif

  // Next-state for accumulator, phase, position and step pulse
  always_comb begin
    last_dir_nx_s = last_dir_r;
    acc_nx_s      = acc_r;
    enc_nx_s      = enc_r;
    pos_nx_s      = pos_r;
    step_nx_s     = 1'b0;
`ifdef QUAD_ENC_INDEX_EN
    rev_nx_s      = rev_r;
`endif
    if (enable) begin
      if (dir_s != last_dir_r) begin
        acc_nx_s      = 16'd0;
        last_dir_nx_s = dir_s;
      end else if ((dir_s != DIR_STOP) && pwm) begin
        if (acc_r == ACC_MAX) begin
          acc_nx_s  = 16'd0;
          step_nx_s = 1'b1;
          enc_nx_s  = next_enc(enc_r, dir_s == DIR_FWD);
          if (dir_s == DIR_FWD) begin
            pos_nx_s = pos_r + 16'd1;
`ifdef QUAD_ENC_INDEX_EN
            rev_nx_s = (rev_r == REV_MAX) ? 32'd0 : rev_r + 32'd1;
`endif
          end else begin
            pos_nx_s = pos_r - 16'd1;
`ifdef QUAD_ENC_INDEX_EN
            rev_nx_s = (rev_r == 32'd0) ? REV_MAX : rev_r - 32'd1;
`endif
          end
        end else begin
          acc_nx_s = acc_r + 16'd1;
        end
      end else begin
        acc_nx_s = acc_r;
      end
    end else begin
      step_nx_s = 1'b0;
    end
  end

  // State registers; reset wins over every other input
  always_ff @(posedge clk) begin
    if (reset) begin
      last_dir_r <= DIR_STOP;
      acc_r      <= 16'd0;
      enc_r      <= 2'b00;
      pos_r      <= 16'd0;
      step_r     <= 1'b0;
`ifdef QUAD_ENC_INDEX_EN
      rev_r      <= 32'd0;
      idx_r      <= 1'b1;
`endif
    end else begin
      last_dir_r <= last_dir_nx_s;
      acc_r      <= acc_nx_s;
      enc_r      <= enc_nx_s;
      pos_r      <= pos_nx_s;
      step_r     <= step_nx_s;
`ifdef QUAD_ENC_INDEX_EN
      rev_r      <= rev_nx_s;
      idx_r      <= (rev_nx_s == 32'd0) && (enc_nx_s == 2'b00);
`endif
    end
  end

  assign enc  = enc_r;
  assign pos  = pos_r;
  assign step = step_r;
`ifdef QUAD_ENC_INDEX_EN
  assign idx  = idx_r;
`else
  assign idx  = 1'b0;
`endif
endmodule

module quad_encoder_gen #(
  parameter int unsigned STEP_DIV       = 64,
  parameter int unsigned COUNTS_PER_REV = 1440
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in1,
  input  logic               in2,
  input  logic               in3,
  input  logic               in4,
  input  logic               pwm,
  input  logic               enable,
  output logic [1:0]         r_enc,
  output logic [1:0]         l_enc,
  output logic signed [15:0] r_pos,
  output logic signed [15:0] l_pos,
  output logic               r_step,
  output logic               l_step,
  output logic               r_idx,
  output logic               l_idx
);
  quad_encoder_side #(.STEP_DIV(STEP_DIV), .COUNTS_PER_REV(COUNTS_PER_REV)) u_right (
    .clk(clk), .reset(reset), .enable(enable), .pwm(pwm),
    .drv_a(in1), .drv_b(in2),
    .enc(r_enc), .pos(r_pos), .step(r_step), .idx(r_idx)
  );

  quad_encoder_side #(.STEP_DIV(STEP_DIV), .COUNTS_PER_REV(COUNTS_PER_REV)) u_left (
    .clk(clk), .reset(reset), .enable(enable), .pwm(pwm),
    .drv_a(in3), .drv_b(in4),
    .enc(l_enc), .pos(l_pos), .step(l_step), .idx(l_idx)
  );
endmodule

// File: tb/tb_quad_encoder_gen.sv
// Self-checking bench for quad_encoder_gen: net-step-count reference model plus pinned literal expectations.
module tb_quad_encoder_gen;
  localparam int SD  = 2;
  localparam int CPR = 8;

  logic clk = 1'b0;
  logic reset, in1, in2, in3, in4, pwm, enable;
  logic [1:0] r_enc, l_enc;
  logic signed [15:0] r_pos, l_pos;
  logic r_step, l_step, r_idx, l_idx;

  int n_checks = 0;
  int n_errors = 0;

  // model: direction latch, active-cycle count, net step count per side (0 = right, 1 = left)
  int m_last[2];
  int m_cnt[2];
  int m_p[2];
  bit m_step[2];
  logic [1:0] enc_tab[4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  quad_encoder_gen #(.STEP_DIV(SD), .COUNTS_PER_REV(CPR)) dut (
    .clk(clk), .reset(reset), .in1(in1), .in2(in2), .in3(in3), .in4(in4),
    .pwm(pwm), .enable(enable),
    .r_enc(r_enc), .l_enc(l_enc), .r_pos(r_pos), .l_pos(l_pos),
    .r_step(r_step), .l_step(l_step), .r_idx(r_idx), .l_idx(l_idx)
  );

  always #5 clk = ~clk;

  function automatic int pmod(input int a, input int m);
    pmod = ((a % m) + m) % m;
  endfunction

  function automatic int side_dir(input int s);
    logic a, b;
    a = (s == 0) ? in1 : in3;
    b = (s == 0) ? in2 : in4;
    if (a && !b)      side_dir = 1;
    else if (!a && b) side_dir = -1;
    else              side_dir = 0;
  endfunction

  function automatic logic [1:0] exp_enc(input int s);
    exp_enc = enc_tab[pmod(m_p[s], 4)];
  endfunction

  function automatic logic exp_idx(input int s);
`ifdef QUAD_ENC_INDEX_EN
    exp_idx = (pmod(m_p[s], CPR) == 0) && (exp_enc(s) == 2'b00);
`else
    exp_idx = 1'b0;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("r_enc",  {30'd0, r_enc},  {30'd0, exp_enc(0)});
    chk("l_enc",  {30'd0, l_enc},  {30'd0, exp_enc(1)});
    chk("r_pos",  {16'd0, r_pos},  {16'd0, 16'(m_p[0])});
    chk("l_pos",  {16'd0, l_pos},  {16'd0, 16'(m_p[1])});
    chk("r_step", {31'd0, r_step}, {31'd0, m_step[0]});
    chk("l_step", {31'd0, l_step}, {31'd0, m_step[1]});
    chk("r_idx",  {31'd0, r_idx},  {31'd0, exp_idx(0)});
    chk("l_idx",  {31'd0, l_idx},  {31'd0, exp_idx(1)});
  endtask

  // one clock: model follows the sampled inputs, then outputs are compared 1 time unit later
  task automatic cyc();
    @(posedge clk);
    for (int s = 0; s < 2; s++) begin
      int d;
      d = side_dir(s);
      if (reset) begin
        m_last[s] = 0; m_cnt[s] = 0; m_p[s] = 0; m_step[s] = 1'b0;
      end else if (!enable) begin
        m_step[s] = 1'b0;
      end else if (d != m_last[s]) begin
        m_last[s] = d; m_cnt[s] = 0; m_step[s] = 1'b0;
      end else if (d != 0 && pwm) begin
        m_step[s] = 1'b0;
        m_cnt[s]++;
        if (m_cnt[s] == SD) begin
          m_cnt[s] = 0; m_p[s] += d; m_step[s] = 1'b1;
        end
      end else begin
        m_step[s] = 1'b0;
      end
    end
    #1;
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic set_in(input logic [3:0] v);
    {in1, in2, in3, in4} = v;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  logic idx_rst;

  initial begin
`ifdef QUAD_ENC_INDEX_EN
    idx_rst = 1'b1;
`else
    idx_rst = 1'b0;
`endif
    reset = 1'b1; enable = 1'b0; pwm = 1'b0; set_in(4'b0000);
    run(2);
    chk("rst_r_enc", {30'd0, r_enc}, 32'd0);
    chk("rst_r_pos", {16'd0, r_pos}, 32'd0);
    chk("rst_l_step", {31'd0, l_step}, 32'd0);
    chk("rst_r_idx", {31'd0, r_idx}, {31'd0, idx_rst});

    // both forward at full duty: latch edge, then a step every SD edges
    reset = 1'b0; enable = 1'b1; pwm = 1'b1; set_in(4'b1010);
    run(3);
    chk("fwd_first_enc", {30'd0, r_enc}, 32'd2);
    chk("fwd_first_step", {31'd0, r_step}, 32'd1);
    run(6);
    chk("fwd_r_pos4", {16'd0, r_pos}, 32'd4);
    chk("fwd_l_pos4", {16'd0, l_pos}, 32'd4);
    chk("fwd_enc_back", {30'd0, r_enc}, 32'd0);

    // right reverse at 50% duty, left braked
    do_reset();
    set_in(4'b0100);
    for (int i = 0; i < 16; i++) begin
      pwm = i[0] ? 1'b0 : 1'b1;
      cyc();
    end
    chk("stop_l_pos", {16'd0, l_pos}, 32'd0);
    chk("stop_l_enc", {30'd0, l_enc}, 32'd0);

    // direction change mid-count: no step on the switch edge
    pwm = 1'b1;
    do_reset();
    set_in(4'b1010);
    run(4);
    set_in(4'b0110);
    cyc();
    chk("switch_no_step", {31'd0, r_step}, 32'd0);
    chk("switch_pos_held", {16'd0, r_pos}, 32'd1);
    run(2);
    chk("switch_rev_pos", {16'd0, r_pos}, 32'd0);

    // reset mid-count, then enable low freezes everything
    set_in(4'b1010);
    run(5);
    do_reset();
    chk("midrst_pos", {16'd0, r_pos}, 32'd0);
    chk("midrst_enc", {30'd0, r_enc}, 32'd0);
    run(4);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      pwm = 1'(($urandom % 2));
      set_in(4'($urandom));
      cyc();
    end
    enable = 1'b1; pwm = 1'b1;

    // position wrap in both directions
    do_reset();
    set_in(4'b1001);
    run(1 + 2 * 32767);
    chk("wrap_r_max", {16'd0, r_pos}, 32'h7fff);
    chk("wrap_l_minp1", {16'd0, l_pos}, 32'h8001);
    run(2);
    chk("wrap_r_min", {16'd0, r_pos}, 32'h8000);
    chk("wrap_l_min", {16'd0, l_pos}, 32'h8000);
    set_in(4'b0110);
    run(3);
    chk("unwrap_r", {16'd0, r_pos}, 32'h7fff);
    chk("unwrap_l", {16'd0, l_pos}, 32'h8001);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom % 32 == 0) set_in(4'($urandom));
      pwm    = ($urandom % 4) != 0;
      enable = ($urandom % 16) != 0;
      reset  = ($urandom % 500) == 0;
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
